serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial 16-bit add/subtract unit built around a single `full_adder` cell. The block sequences that cell LSB-first over 16 clock cycles, holding the carry in a flip-flop between bits. It presents a start/busy/done handshake to the CPU control path. It is the area-minimal ALU arithmetic path: one adder cell, operand shift registers and a small FSM in place of a 16-bit ripple chain.

## Interface
Parameters:
- `WIDTH`, 16: operand and result width; the counter is `$clog2(WIDTH)` bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a new operation; sampled only in IDLE or DONE
- `op_sub`  in  1  0 = a+b, 1 = a−b; sampled with `start`
- `a`  in  WIDTH  operand A; sampled with `start`
- `b`  in  WIDTH  operand B; sampled with `start`
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse when the result becomes valid
- `result`  out  WIDTH  sum or difference; held stable from `done` until the next accepted `start`
- `carry_out`  out  1  carry out of the MSB; for subtract, 1 = no borrow
- `overflow`  out  1  two's-complement overflow
- `zero`  out  1  result == 0

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE or DONE with `start`=1 (accept):**
  - Load `a_sr` ← a.
  - Load `b_sr` ← (op_sub ? ~b : b).
  - Load `c` ← op_sub.
  - Clear `cnt` ← 0 and `res_sr` ← 0.
  - Go to RUN.
- **IDLE or DONE with `start`=0:** go to or stay in IDLE. Outputs hold.
- **RUN, each cycle:**
  - `full_adder` inputs: a_sr[0], b_sr[0], c.
  - `res_sr` ← {sum, res_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by 1.
  - c ← cout and cnt ← cnt+1.
- **RUN, when cnt == WIDTH-1:**
  - Capture `overflow` ← c XOR cout (carry into MSB XOR carry out of MSB).
  - Capture `carry_out` ← cout.
  - `zero` ← ({sum, res_sr[WIDTH-1:1]} == 0).
  - Go to DONE.
- **`start` during RUN:** ignored. No queuing, no restart, operands unaffected.
- **`result`:** driven directly from `res_sr`. It is only guaranteed meaningful while `done`=1 and afterwards until the next accept. Intermediate shift values are visible during RUN.
- **Flags:** `carry_out`, `overflow`, `zero` are registered and change only at the RUN→DONE edge.

## Timing
- **Reset (async assert, synchronous-safe deassert):**
  - state = IDLE.
  - busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0.
  - cnt=0, c=0, a_sr=b_sr=0.
- **Accept:** `start` high at edge E0. `busy`=1 from E0 through E16. RUN occupies cycles E0..E15 (16 bit-cycles).
- **Latency:** `done`=1 for exactly the cycle after edge E16. `busy`=0 in that cycle. Start-to-done latency is 16 cycles; `busy` and `done` are never high together.
- **Back-to-back:** `start`=1 while `done`=1 is accepted. Next RUN begins the following cycle, giving a throughput of one operation per 17 cycles.
- **Reset asserted mid-RUN:** operation is aborted immediately and all outputs go to reset values. No `done` is produced for the aborted operation.
- **`cnt` wrap:** impossible; the FSM leaves RUN at WIDTH-1.

## Structure
- Shared package `cpu_pkg`:
  - `localparam WIDTH = 16`.
  - Typedef `add_state_t` enum {IDLE, RUN, DONE}, reused by other multi-cycle ALU controllers.
- One sub-module: `full_adder` (a, b, cin → sum, cout), instantiated once. The controller contains no other arithmetic apart from the counter increment.
- All registers are in one `always` block with async active-low reset. Next-state and output decode are combinational.

## Test plan
- a=0x1234, b=0x0001, op_sub=0 → `done` exactly 16 cycles after the start edge; result=0x1235, carry_out=0, overflow=0, zero=0.
- a=0xFFFF, b=0x0001, add → result=0x0000, carry_out=1, overflow=0, zero=1.
- a=0x7FFF, b=0x0001, add → result=0x8000, overflow=1, carry_out=0. Also a=0x8000, b=0xFFFF → result=0x7FFF, overflow=1, carry_out=1.
- a=0x0005, b=0x0007, op_sub=1 → result=0xFFFE, carry_out=0 (borrow). Then a=7, b=5 → result=0x0002, carry_out=1.
- Pulse `start` with different operands at cycles 3 and 10 of RUN → ignored; first result unchanged. `start` held high during `done` → second operation is accepted and its own `done` arrives 17 cycles after the first.
- Assert `rst_n`=0 at RUN cycle 8 → busy, done and all flags go to 0 asynchronously. After release with no `start`, no `done` ever appears. A fresh add of 1+1 then gives 0x0002.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types for the multi-cycle ALU controllers.
// Holds the default word width and the common add-sequencer state type.
package cpu_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// The only adder cell used by the bit-serial arithmetic path.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract unit: one full adder cell sequenced LSB-first.
// Start/busy/done handshake; result and flags held after completion.
module serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  import cpu_pkg::*;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  add_state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             z_q, z_d;

  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             in_run;
  logic [WIDTH-1:0] res_next;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign in_run   = (state_q == RUN);
  assign accept   = start & ((state_q == IDLE) | (state_q == DONE));
  assign res_next = {fa_sum, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    co_d    = co_q;
    ov_d    = ov_q;
    z_d     = z_q;
    unique case (1'b1)
      accept: begin
        a_d     = a;
        b_d     = op_sub ? ~b : b;
        c_d     = op_sub;
        cnt_d   = '0;
        res_d   = '0;
        state_d = RUN;
      end
      in_run: begin
        res_d = res_next;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_cout;
        cnt_d = cnt_q + CW'(1);
        // Last bit: c_q is the carry into the MSB
        if (cnt_q == LAST) begin
          ov_d    = c_q ^ fa_cout;
          co_d    = fa_cout;
          z_d     = (res_next == '0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
    end
  end

  assign busy      = in_run;
  assign done      = (state_q == DONE);
  assign result    = res_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;
  assign zero      = z_q;

endmodule
